// File: rtl/axis_out_deadlock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : axis_out_deadlock_monitor
// Description : Passive monitor on a kernel AXI-Stream output port. Flags a
//               persistent TVALID-without-TREADY stall while all other
//               instances are idle, and keeps saturating traffic statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_out_deadlock_monitor #(
    parameter int IDLE_W = 2,
    parameter int THRESH = 16,
    parameter int CNT_W  = 32
) (
    input  logic              kernel_monitor_clock,
    input  logic              kernel_monitor_reset,
    input  logic              axis_tvalid,
    input  logic              axis_tready,
    input  logic              axis_tlast,
    input  logic [IDLE_W-1:0] inst_idle_sigs,
    input  logic              clear,
    output logic              block,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  beat_count,
    output logic [CNT_W-1:0]  packet_count,
    output logic [CNT_W-1:0]  first_block_time
);

    localparam int                 c_RUN_W    = $clog2(THRESH) + 1;
    localparam logic [c_RUN_W-1:0] c_RUN_LAST = c_RUN_W'(THRESH - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_RUN_W-1:0] r_run;
    logic [c_RUN_W-1:0] w_run_nxt;
    logic               w_enter_block;
    logic               r_block;
    logic [CNT_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_stall_cycles;
    logic [CNT_W-1:0]   r_beat_count;
    logic [CNT_W-1:0]   r_packet_count;
    logic [CNT_W-1:0]   r_first_block_time;

    logic w_hs;
    logic w_stl;
    logic w_q;

    assign w_hs  = axis_tvalid & axis_tready;
    assign w_stl = axis_tvalid & ~axis_tready;
    assign w_q   = w_stl & (&inst_idle_sigs);

    always_comb begin
        w_state_nxt   = r_state;
        w_run_nxt     = r_run;
        w_enter_block = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_q) begin
                    w_state_nxt = ST_STALL;
                    w_run_nxt   = c_RUN_W'(1);
                end else begin
                    w_run_nxt   = '0;
                end
            end
            ST_STALL: begin
                if (!w_q) begin
                    w_state_nxt = ST_RUN;
                    w_run_nxt   = '0;
                end else if (r_run == c_RUN_LAST) begin
                    w_state_nxt   = ST_BLOCKED;
                    w_enter_block = 1'b1;
                end else begin
                    w_run_nxt = r_run + c_RUN_W'(1);
                end
            end
            ST_BLOCKED: begin
                w_state_nxt = ST_BLOCKED;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_run_nxt   = '0;
            end
        endcase
    end

    // clear shares the reset path so a coinciding event is never counted
    always_ff @(posedge kernel_monitor_clock) begin
        if (kernel_monitor_reset || clear) begin
            r_state            <= ST_RUN;
            r_run              <= '0;
            r_block            <= 1'b0;
            r_timer            <= '0;
            r_stall_cycles     <= '0;
            r_beat_count       <= '0;
            r_packet_count     <= '0;
            r_first_block_time <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_timer <= r_timer + CNT_W'(1);
            if (w_stl && (r_stall_cycles != c_CNT_MAX))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (w_hs && (r_beat_count != c_CNT_MAX))
                r_beat_count <= r_beat_count + CNT_W'(1);
            if (w_hs && axis_tlast && (r_packet_count != c_CNT_MAX))
                r_packet_count <= r_packet_count + CNT_W'(1);
            if (w_enter_block) begin
                r_block            <= 1'b1;
                r_first_block_time <= r_timer;
            end
        end
    end

    assign block            = r_block;
    assign state            = r_state;
    assign stall_cycles     = r_stall_cycles;
    assign beat_count       = r_beat_count;
    assign packet_count     = r_packet_count;
    assign first_block_time = r_first_block_time;

endmodule
`default_nettype wire

// File: tb/tb_axis_out_deadlock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_out_deadlock_monitor
// Description : Randomized and directed bench for axis_out_deadlock_monitor
//               against a streak-counting reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_out_deadlock_monitor;

    localparam int THRESH = 16;
    localparam int IDLE_W = 2;

    logic              clk;
    logic              rst;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [IDLE_W-1:0] idle;
    logic              clr;

    logic        blk;
    logic [1:0]  st;
    logic [31:0] stall_o;
    logic [31:0] beat_o;
    logic [31:0] pkt_o;
    logic [31:0] fbt_o;

    logic        s_blk;
    logic [1:0]  s_st;
    logic [3:0]  s_stall;
    logic [3:0]  s_beat;
    logic [3:0]  s_pkt;
    logic [3:0]  s_fbt;

    int errors = 0;
    int checks = 0;

    // reference model state
    longint m_timer, m_stall, m_beat, m_pkt, m_fbt;
    int     m_streak;
    bit     m_block;

    axis_out_deadlock_monitor #(.IDLE_W(IDLE_W), .THRESH(THRESH), .CNT_W(32)) u_dut (
        .kernel_monitor_clock (clk),
        .kernel_monitor_reset (rst),
        .axis_tvalid          (tvalid),
        .axis_tready          (tready),
        .axis_tlast           (tlast),
        .inst_idle_sigs       (idle),
        .clear                (clr),
        .block                (blk),
        .state                (st),
        .stall_cycles         (stall_o),
        .beat_count           (beat_o),
        .packet_count         (pkt_o),
        .first_block_time     (fbt_o)
    );

    axis_out_deadlock_monitor #(.IDLE_W(IDLE_W), .THRESH(THRESH), .CNT_W(4)) u_dut_small (
        .kernel_monitor_clock (clk),
        .kernel_monitor_reset (rst),
        .axis_tvalid          (tvalid),
        .axis_tready          (tready),
        .axis_tlast           (tlast),
        .inst_idle_sigs       (idle),
        .clear                (clr),
        .block                (s_blk),
        .state                (s_st),
        .stall_cycles         (s_stall),
        .beat_count           (s_beat),
        .packet_count         (s_pkt),
        .first_block_time     (s_fbt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint sat(longint v, int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [1:0] m_state();
        if (m_block) return 2'd2;
        return (m_streak > 0) ? 2'd1 : 2'd0;
    endfunction

    // Apply one cycle of inputs, advance the model on the sampling edge,
    // and leave outputs settled for comparison.
    task automatic step(input logic v, input logic r, input logic l,
                        input logic [IDLE_W-1:0] id, input logic c, input logic rs);
        bit q;
        tvalid = v; tready = r; tlast = l; idle = id; clr = c; rst = rs;
        @(posedge clk);
        if (rs || c) begin
            m_timer = 0; m_stall = 0; m_beat = 0; m_pkt = 0; m_fbt = 0;
            m_streak = 0; m_block = 0;
        end else begin
            q = v && !r && (&id);
            if (!m_block) begin
                if (q) begin
                    m_streak++;
                    if (m_streak == THRESH) begin
                        m_block = 1;
                        m_fbt   = m_timer;
                    end
                end else begin
                    m_streak = 0;
                end
            end
            if (v && !r) m_stall++;
            if (v && r) m_beat++;
            if (v && r && l) m_pkt++;
            m_timer++;
        end
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 2'b11, 0, 1);
        step(0, 0, 0, 2'b11, 0, 0);
        checks++;
        if ({blk, st, stall_o, beat_o, pkt_o, fbt_o} !== '0) begin
            errors++;
            $display("FAIL reset: block=%0d state=%0d stall=%0d beat=%0d pkt=%0d fbt=%0d expected all 0",
                     blk, st, stall_o, beat_o, pkt_o, fbt_o);
        end
    endtask

    task automatic test_handshake();
        step(0, 0, 0, 2'b11, 0, 1);
        for (int i = 1; i <= 10; i++) step(1, 1, (i % 5 == 0), 2'b11, 0, 0);
        step(0, 0, 0, 2'b11, 0, 0);
        checks++;
        if (beat_o !== 32'd10 || pkt_o !== 32'd2 || stall_o !== 32'd0 || blk !== 1'b0) begin
            errors++;
            $display("FAIL handshake: beat=%0d pkt=%0d stall=%0d block=%0d expected 10 2 0 0",
                     beat_o, pkt_o, stall_o, blk);
        end
    endtask

    task automatic test_deadlock();
        step(0, 0, 0, 2'b11, 0, 1);
        for (int i = 0; i < 19; i++) step(0, 0, 0, 2'b11, 0, 0);
        for (int i = 1; i < THRESH; i++) step(1, 0, 0, 2'b11, 0, 0);
        checks++;
        if (blk !== 1'b0 || st !== 2'd1) begin
            errors++;
            $display("FAIL deadlock_early: block=%0d state=%0d expected 0 1", blk, st);
        end
        step(1, 0, 0, 2'b11, 0, 0);
        checks++;
        if (blk !== 1'b1 || st !== 2'd2 || fbt_o !== 32'(m_fbt)) begin
            errors++;
            $display("FAIL deadlock_block: block=%0d state=%0d fbt=%0d expected 1 2 %0d",
                     blk, st, fbt_o, m_fbt);
        end
        for (int i = 0; i < 5; i++) step(1, 1, 0, 2'b00, 0, 0);
        checks++;
        if (blk !== 1'b1 || st !== 2'd2 || fbt_o !== 32'(m_fbt) || beat_o !== 32'd5) begin
            errors++;
            $display("FAIL deadlock_sticky: block=%0d state=%0d fbt=%0d beat=%0d expected 1 2 %0d 5",
                     blk, st, fbt_o, beat_o, m_fbt);
        end
    endtask

    task automatic test_near_miss();
        step(0, 0, 0, 2'b11, 0, 1);
        for (int i = 0; i < THRESH - 1; i++) step(1, 0, 0, 2'b11, 0, 0);
        step(1, 1, 0, 2'b11, 0, 0);
        for (int i = 0; i < THRESH - 1; i++) step(1, 0, 0, 2'b11, 0, 0);
        checks++;
        if (blk !== 1'b0 || stall_o !== 32'd30 || beat_o !== 32'd1 || st !== 2'd1) begin
            errors++;
            $display("FAIL near_miss: block=%0d stall=%0d beat=%0d state=%0d expected 0 30 1 1",
                     blk, stall_o, beat_o, st);
        end
    endtask

    task automatic test_busy();
        bit bad;
        step(0, 0, 0, 2'b11, 0, 1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(1, 0, 0, 2'b01, 0, 0);
            if (st !== 2'd0) bad = 1;
        end
        checks++;
        if (blk !== 1'b0 || bad || stall_o !== 32'd100) begin
            errors++;
            $display("FAIL busy: block=%0d left_run=%0d stall=%0d expected 0 0 100", blk, bad, stall_o);
        end
    endtask

    task automatic test_clear_priority();
        step(0, 0, 0, 2'b11, 0, 1);
        for (int i = 0; i < THRESH + 3; i++) step(1, 0, 0, 2'b11, 0, 0);
        step(1, 1, 1, 2'b11, 0, 0);
        checks++;
        if (blk !== 1'b1 || st !== 2'd2) begin
            errors++;
            $display("FAIL clear_pre: block=%0d state=%0d expected 1 2", blk, st);
        end
        step(1, 1, 1, 2'b11, 1, 0);
        checks++;
        if ({blk, st, stall_o, beat_o, pkt_o, fbt_o} !== '0) begin
            errors++;
            $display("FAIL clear_priority: block=%0d state=%0d stall=%0d beat=%0d pkt=%0d fbt=%0d expected all 0",
                     blk, st, stall_o, beat_o, pkt_o, fbt_o);
        end
    endtask

    task automatic test_saturation();
        step(0, 0, 0, 2'b11, 0, 1);
        for (int i = 0; i < 20; i++) step(1, 1, 1, 2'b11, 0, 0);
        checks++;
        if (s_beat !== 4'd15 || s_pkt !== 4'd15 || beat_o !== 32'd20) begin
            errors++;
            $display("FAIL saturation: small_beat=%0d small_pkt=%0d wide_beat=%0d expected 15 15 20",
                     s_beat, s_pkt, beat_o);
        end
        for (int i = 0; i < 20; i++) step(1, 0, 0, 2'b11, 0, 0);
        checks++;
        if (s_stall !== 4'd15 || s_blk !== 1'b1 || s_fbt !== 4'(m_fbt)) begin
            errors++;
            $display("FAIL saturation_stall: small_stall=%0d small_block=%0d small_fbt=%0d expected 15 1 %0d",
                     s_stall, s_blk, s_fbt, m_fbt & 15);
        end
        step(0, 0, 0, 2'b11, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 2'b11, 0, 0);
        step(1, 0, 0, 2'b11, 0, 1);
        checks++;
        if ({blk, st, stall_o, beat_o, pkt_o, fbt_o} !== '0 || {s_blk, s_st, s_stall, s_beat} !== '0) begin
            errors++;
            $display("FAIL reset_mid_stall: block=%0d state=%0d stall=%0d beat=%0d small_stall=%0d expected all 0",
                     blk, st, stall_o, beat_o, s_stall);
        end
    endtask

    task automatic test_random();
        int rdy_pct;
        logic [IDLE_W-1:0] id;
        step(0, 0, 0, 2'b11, 0, 1);
        for (int i = 0; i < 1200; i++) begin
            if (i % 60 == 0) rdy_pct = (($urandom % 2) == 0) ? 2 : 40;
            id = (($urandom % 20) == 0) ? IDLE_W'($urandom) : '1;
            step(($urandom % 5) != 0, ($urandom % 100) < rdy_pct, $urandom % 2, id,
                 ($urandom % 150) == 0, 0);
            checks++;
            if (blk !== m_block || st !== m_state() || stall_o !== 32'(m_stall) ||
                beat_o !== 32'(m_beat) || pkt_o !== 32'(m_pkt) || fbt_o !== 32'(m_fbt) ||
                s_beat !== 4'(sat(m_beat, 4)) || s_stall !== 4'(sat(m_stall, 4))) begin
                errors++;
                $display("FAIL random[%0d]: block=%0d/%0d state=%0d/%0d stall=%0d/%0d beat=%0d/%0d pkt=%0d/%0d fbt=%0d/%0d small_beat=%0d/%0d (actual/required)",
                         i, blk, m_block, st, m_state(), stall_o, m_stall, beat_o, m_beat,
                         pkt_o, m_pkt, fbt_o, m_fbt, s_beat, sat(m_beat, 4));
            end
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; idle = '1;
        m_timer = 0; m_stall = 0; m_beat = 0; m_pkt = 0; m_fbt = 0; m_streak = 0; m_block = 0;
        test_reset();
        test_handshake();
        test_deadlock();
        test_near_miss();
        test_busy();
        test_clear_priority();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_out_deadlock_monitor.md
# axis_out_deadlock_monitor

Simulation/debug monitor for the master (output) side of a kernel AXI-Stream port, e.g. the hypervector result stream `sdata_o` of `hdv_engine`. It detects a persistent backpressure deadlock: TVALID held high and TREADY held low while every other monitored instance is idle. It also keeps saturating traffic statistics. It is the transmit-side counterpart of the existing input-port block diagnosis and sits beside the kernel in the simulation top, observing only.

## Interface
- `IDLE_W`, default 2: number of instance idle inputs. Tie unused bits to 1.
- `THRESH`, default 16: consecutive qualifying stall cycles before `block` asserts. Legal range is 2 or more.
- `CNT_W`, default 32: width of all statistic counters and the timer.

Ports (all outputs registered):
- `kernel_monitor_clock`  in  1  monitor clock; all logic on its rising edge.
- `kernel_monitor_reset`  in  1  synchronous, active-high reset.
- `axis_tvalid`  in  1  observed TVALID of the kernel output stream.
- `axis_tready`  in  1  observed TREADY from the downstream consumer.
- `axis_tlast`  in  1  observed TLAST.
- `inst_idle_sigs`  in  IDLE_W  ap_idle of the other kernel instances, 1 = idle.
- `clear`  in  1  synchronous statistics/state clear.
- `block`  out  1  sticky deadlock flag.
- `state`  out  2  FSM state: 0 RUN, 1 STALL, 2 BLOCKED.
- `stall_cycles`  out  CNT_W  total cycles with TVALID=1 and TREADY=0, saturating.
- `beat_count`  out  CNT_W  handshakes (TVALID=1 and TREADY=1), saturating.
- `packet_count`  out  CNT_W  handshakes with TLAST=1, saturating.
- `first_block_time`  out  CNT_W  timer value latched on entry to BLOCKED.

## Operation
- Definitions:
  - `hs` = `axis_tvalid & axis_tready`.
  - `stl` = `axis_tvalid & ~axis_tready`.
  - `q` = `stl & (&inst_idle_sigs)` (qualifying stall).
- Free-running `timer` (CNT_W bits) increments every cycle and wraps modulo 2^CNT_W. It is cleared by reset or `clear`.
- Counters saturate at all-ones and never wrap:
  - `stall_cycles` += `stl`.
  - `beat_count` += `hs`.
  - `packet_count` += `hs & axis_tlast`.
- FSM and run counter `run` (width clog2(THRESH)+1):
  - **RUN:** if `q`, go to STALL with `run`=1; otherwise `run`=0.
  - **STALL:**
    - If `!q`, go to RUN with `run`=0. This covers a TREADY rise, a TVALID drop, or any instance leaving idle.
    - Else if `run == THRESH-1`, go to BLOCKED, set `block`=1, and latch `first_block_time` = current `timer`.
    - Else increment `run`.
  - **BLOCKED:** terminal. `block` stays 1 regardless of inputs; statistics keep counting. Only `clear` or reset leaves this state.
- `clear` has priority over all same-cycle events:
  - Next cycle: state RUN, `run`=0, `block`=0, all counters/timer/`first_block_time`=0.
  - An event coinciding with `clear` is not counted.
- Reset has the same effect as `clear`, including mid-STALL and in BLOCKED.
- The monitor never drives the stream; its inputs are sampled only.

## Timing
- Reset values: `block`=0, `state`=0, all counters and `first_block_time`=0.
- Statistics update on the edge that samples the event and are visible one cycle later.
- `block` latency: if `q` is sampled true on THRESH consecutive edges, starting at edge k, `block` is 1 after edge k+THRESH-1. It is never earlier.
- A single non-qualifying cycle anywhere in the run restarts the count from zero. The next qualifying cycle counts as 1.
- `first_block_time` equals the timer value sampled at the edge that enters BLOCKED. It is written exactly once per clear/reset epoch.
- Saturation: a counter at 2^CNT_W-1 holds its value when its event recurs.
- Simultaneous TREADY rise and threshold reach: `q`=0 that cycle, so the FSM goes to RUN and no block occurs.

## Test plan
- **Handshake traffic:** reset, then 10 beats with TVALID=TREADY=1 and TLAST on beats 5 and 10 → `beat_count`=10, `packet_count`=2, `stall_cycles`=0, `block`=0.
- **Deadlock detect:** THRESH=16, all idle=1, TVALID=1, TREADY=0 from cycle 20 onward → `block` rises after edge 35, `first_block_time`=35, `state`=2. `block` stays 1 after TREADY later rises.
- **Near miss:** 15 qualifying cycles, then TREADY=1 for 1 cycle, then 15 more → `block` stays 0, `stall_cycles`=30, `beat_count`=1.
- **Busy instance:** stall held 100 cycles with `inst_idle_sigs`=2'b01 → `block`=0, `state` stays RUN, `stall_cycles`=100.
- **Clear priority:** in BLOCKED, assert `clear` on the same cycle as a TLAST handshake → next cycle all outputs 0 and `state`=RUN. That handshake is not counted.
- **Saturation and reset:** CNT_W=4 with 20 handshakes → `beat_count`=15. Then reset asserted mid-STALL → all outputs return to reset values the next cycle.
